midi_voice_allocator: RTL and testbench

Polyphonic voice scheduler between the MIDI byte parser and the per-voice synthesis datapath. It accepts decoded MIDI channel events and assigns each note-on to one of `NUM_VOICES` voice slots: a free slot first, otherwise it steals the least-recently-triggered slot. Note-offs release the slot holding that note. Each voice's note number feeds its own `midi_processor`/oscillator instance downstream.

---
 rtl/midi_pkg.sv | 33 +++
 rtl/midi_voice_allocator_lru.sv | 42 ++++
 rtl/midi_voice_allocator.sv | 158 +++++++++++++++
 tb/tb_midi_voice_allocator.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants, event classes and allocator FSM states.
// Imported by the voice allocator and its LRU age tracker.
package midi_pkg;

    localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
    localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
    localparam logic [7:0] MIDDLE_C      = 8'd60;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_ON,
        EV_OFF
    } ev_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } state_t;

    // Velocity-zero note-on is a note-off by MIDI running-status habit.
    function automatic ev_t classify(
        input logic [3:0] st,
        input logic [7:0] vel
    );
        if (st == MIDI_NOTE_ON && vel != 8'd0)
            return EV_ON;
        if (st == MIDI_NOTE_OFF || st == MIDI_NOTE_ON)
            return EV_OFF;
        return EV_NONE;
    endfunction

endpackage

// File: rtl/midi_voice_allocator_lru.sv
// Least-recently-triggered tracker: one age per voice, kept as a permutation.
// Age 0 is the newest trigger, NUM_VOICES-1 the steal candidate.
module voice_lru
    import midi_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int VIDX_W     = $clog2(NUM_VOICES)
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 commit,
    input  logic [VIDX_W-1:0]                    idx,
    output logic [VIDX_W-1:0]                    oldest_idx,
    output logic [NUM_VOICES-1:0][VIDX_W-1:0]    ages
);

    localparam logic [VIDX_W-1:0] AGE_MAX = VIDX_W'(NUM_VOICES - 1);

    // Committed voice becomes newest; younger voices each age by one.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_VOICES; i++)
                ages[i] <= VIDX_W'(NUM_VOICES - 1 - i);
        end else if (commit) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (VIDX_W'(i) == idx)
                    ages[i] <= '0;
                else if (ages[i] < ages[idx])
                    ages[i] <= ages[i] + 1'b1;
            end
        end
    end

    // Locate the voice carrying the maximum age.
    always_comb begin
        oldest_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            if (ages[i] == AGE_MAX)
                oldest_idx = VIDX_W'(i);
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: scans voices one per cycle, then commits
// a note-on (match > free > oldest) or a note-off release.
module midi_voice_allocator
    import midi_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int VIDX_W     = $clog2(NUM_VOICES)
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [3:0]                        status,
    input  logic [7:0]                        data_byte1,
    input  logic [7:0]                        data_byte2,
    input  logic                              valid_in,
    output logic                              ready_out,
    output logic                              drop_out,
    output logic [NUM_VOICES-1:0][7:0]        voice_note,
    output logic [NUM_VOICES-1:0]             voice_gate,
    output logic [NUM_VOICES-1:0]             voice_trigger
);

    localparam logic [VIDX_W-1:0] LAST = VIDX_W'(NUM_VOICES - 1);

    state_t                           state;
    state_t                           state_nxt;
    ev_t                              ev_in;
    ev_t                              ev_q;
    logic [7:0]                       note_q;
    logic [VIDX_W-1:0]                scan_idx;
    logic                             match_found;
    logic [VIDX_W-1:0]                match_idx;
    logic                             free_found;
    logic [VIDX_W-1:0]                free_idx;
    logic                             old_found;
    logic [VIDX_W-1:0]                old_idx;
    logic [VIDX_W-1:0]                target;
    logic                             accept;
    logic                             lru_commit;
    logic [VIDX_W-1:0]                lru_oldest;
    logic [NUM_VOICES-1:0][VIDX_W-1:0] ages;

    assign ev_in      = classify(status, data_byte2);
    assign lru_commit = (state == COMMIT) && (ev_q == EV_ON);

    voice_lru #(
        .NUM_VOICES (NUM_VOICES),
        .VIDX_W     (VIDX_W)
    ) u_lru (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .commit     (lru_commit),
        .idx        (target),
        .oldest_idx (lru_oldest),
        .ages       (ages)
    );

    // Note-on target: retrigger a match, else a free voice, else steal.
    always_comb begin
        target = lru_oldest;
        if (match_found)
            target = match_idx;
        else if (free_found)
            target = free_idx;
        else if (old_found)
            target = old_idx;
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        ready_out = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                ready_out = 1'b1;
                accept    = valid_in && (ev_in != EV_NONE);
                if (accept)
                    state_nxt = SCAN;
            end
            SCAN: begin
                if (scan_idx == LAST)
                    state_nxt = COMMIT;
            end
            COMMIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Event latch, per-voice scan recording and commit of voice state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_VOICES; i++)
                voice_note[i] <= MIDDLE_C;
            voice_gate    <= '0;
            voice_trigger <= '0;
            drop_out      <= 1'b0;
            ev_q          <= EV_NONE;
            note_q        <= '0;
            scan_idx      <= '0;
            match_found   <= 1'b0;
            match_idx     <= '0;
            free_found    <= 1'b0;
            free_idx      <= '0;
            old_found     <= 1'b0;
            old_idx       <= '0;
        end else begin
            drop_out      <= valid_in && (state != IDLE);
            voice_trigger <= '0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        ev_q        <= ev_in;
                        note_q      <= data_byte1;
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        old_found   <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!match_found && voice_gate[scan_idx] &&
                        voice_note[scan_idx] == note_q) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!free_found && !voice_gate[scan_idx]) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    if (ages[scan_idx] == LAST) begin
                        old_found <= 1'b1;
                        old_idx   <= scan_idx;
                    end
                    scan_idx <= scan_idx + 1'b1;
                end
                COMMIT: begin
                    if (ev_q == EV_ON) begin
                        voice_note[target]    <= note_q;
                        voice_gate[target]    <= 1'b1;
                        voice_trigger[target] <= 1'b1;
                    end else if (ev_q == EV_OFF && match_found) begin
                        voice_gate[match_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Self-checking bench for midi_voice_allocator (4 voices): directed
// scenarios plus random events against a queue-based LRU reference model.
module tb_midi_voice_allocator;

    localparam int NV = 4;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic [3:0]       status = '0;
    logic [7:0]       data_byte1 = '0;
    logic [7:0]       data_byte2 = '0;
    logic             valid_in = 1'b0;
    logic             ready_out;
    logic             drop_out;
    logic [NV-1:0][7:0] voice_note;
    logic [NV-1:0]    voice_gate;
    logic [NV-1:0]    voice_trigger;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_note [NV];
    bit         m_gate [NV];
    int         order [$];

    midi_voice_allocator #(.NUM_VOICES(NV)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .status        (status),
        .data_byte1    (data_byte1),
        .data_byte2    (data_byte2),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .drop_out      (drop_out),
        .voice_note    (voice_note),
        .voice_gate    (voice_gate),
        .voice_trigger (voice_trigger)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_notes();
        logic [31:0] v;
        for (int i = 0; i < NV; i++)
            v[i*8 +: 8] = m_note[i];
        return v;
    endfunction

    function automatic logic [31:0] exp_gates();
        logic [31:0] v = '0;
        for (int i = 0; i < NV; i++)
            v[i] = m_gate[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_note[i] = 8'd60;
            m_gate[i] = 1'b0;
        end
        // front = most recently triggered, back = oldest (voice 0)
        order = {3, 2, 1, 0};
    endtask

    // Apply an event to the reference model; returns expected trigger.
    task automatic model_apply(input logic [3:0] st, input logic [7:0] n,
                               input logic [7:0] v,
                               output logic [31:0] trig);
        int t;
        trig = '0;
        t = -1;
        if (st == 4'h9 && v != 0) begin
            for (int i = 0; i < NV; i++)
                if (t < 0 && m_gate[i] && m_note[i] == n) t = i;
            for (int i = 0; i < NV; i++)
                if (t < 0 && !m_gate[i]) t = i;
            if (t < 0) t = order[$];
            m_note[t] = n;
            m_gate[t] = 1'b1;
            trig[t] = 1'b1;
            for (int k = 0; k < order.size(); k++)
                if (order[k] == t) begin
                    order.delete(k);
                    break;
                end
            order.push_front(t);
        end else if (st == 4'h8 || st == 4'h9) begin
            for (int i = 0; i < NV; i++)
                if (t < 0 && m_gate[i] && m_note[i] == n) t = i;
            if (t >= 0) m_gate[t] = 1'b0;
        end
    endtask

    function automatic bit is_event(input logic [3:0] st);
        return st == 4'h8 || st == 4'h9;
    endfunction

    task automatic check_all(input string tag, input logic [31:0] trig);
        chk({tag, "_note"}, voice_note, exp_notes());
        chk({tag, "_gate"}, {28'd0, voice_gate}, exp_gates());
        chk({tag, "_trig"}, {28'd0, voice_trigger}, trig);
        chk({tag, "_ready"}, {31'd0, ready_out}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        valid_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
    endtask

    // Send one event; checks busy, results in cycle 6 and trigger drop.
    task automatic ev(input string tag, input logic [3:0] st,
                      input logic [7:0] n, input logic [7:0] v);
        logic [31:0] trig;
        @(negedge clk_in);
        chk({tag, "_idle"}, {31'd0, ready_out}, 32'd1);
        status = st;
        data_byte1 = n;
        data_byte2 = v;
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        model_apply(st, n, v, trig);
        if (!is_event(st)) begin
            check_all({tag, "_none"}, 32'd0);
        end else begin
            chk({tag, "_busy"}, {31'd0, ready_out}, 32'd0);
            repeat (5) @(negedge clk_in);
            check_all(tag, trig);
            @(negedge clk_in);
            chk({tag, "_trig_end"}, {28'd0, voice_trigger}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] trig;
        logic [3:0]  st;
        logic [7:0]  n;
        logic [7:0]  v;
        int          r;

        model_reset();
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check_all("reset", 32'd0);
        chk("reset_drop", {31'd0, drop_out}, 32'd0);

        ev("first_on", 4'h9, 8'd64, 8'd100);
        chk("first_v0", {24'd0, voice_note[0]}, 32'd64);

        do_reset();
        ev("fill0", 4'h9, 8'd60, 8'd90);
        ev("fill1", 4'h9, 8'd62, 8'd90);
        ev("fill2", 4'h9, 8'd64, 8'd90);
        ev("fill3", 4'h9, 8'd65, 8'd90);
        ev("steal0", 4'h9, 8'd67, 8'd90);
        chk("steal0_v0", {24'd0, voice_note[0]}, 32'd67);
        ev("steal1", 4'h9, 8'd69, 8'd90);
        chk("steal1_v1", {24'd0, voice_note[1]}, 32'd69);

        do_reset();
        ev("rel_on0", 4'h9, 8'd60, 8'd80);
        ev("rel_on1", 4'h9, 8'd62, 8'd80);
        ev("rel_on2", 4'h9, 8'd64, 8'd80);
        ev("rel_off", 4'h8, 8'd62, 8'd40);
        chk("rel_gates", {28'd0, voice_gate}, 32'h5);
        ev("free_on", 4'h9, 8'd72, 8'd80);
        chk("free_v1", {24'd0, voice_note[1]}, 32'd72);
        ev("off_unheld", 4'h8, 8'd50, 8'd0);

        do_reset();
        ev("vz_on", 4'h9, 8'd60, 8'd70);
        ev("vz_off", 4'h9, 8'd60, 8'd0);
        chk("vz_gate", {28'd0, voice_gate}, 32'h0);
        ev("retrig_a", 4'h9, 8'd64, 8'd70);
        ev("retrig_b", 4'h9, 8'd64, 8'd70);
        chk("retrig_one", {28'd0, voice_gate}, 32'h1);

        // busy drop: valid at cycle 0 and cycle 2
        @(negedge clk_in);
        status = 4'h9; data_byte1 = 8'd66; data_byte2 = 8'd50;
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        model_apply(4'h9, 8'd66, 8'd50, trig);
        @(negedge clk_in);
        status = 4'h9; data_byte1 = 8'd99; data_byte2 = 8'd50;
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        chk("drop_hi", {31'd0, drop_out}, 32'd1);
        @(negedge clk_in);
        chk("drop_lo", {31'd0, drop_out}, 32'd0);
        repeat (2) @(negedge clk_in);
        check_all("drop_res", trig);

        ev("stat_b", 4'hB, 8'd61, 8'd10);

        // reset during scan aborts the note-on
        do_reset();
        @(negedge clk_in);
        status = 4'h9; data_byte1 = 8'd70; data_byte2 = 8'd100;
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check_all("midscan_rst", 32'd0);
        repeat (6) @(negedge clk_in);
        check_all("midscan_after", 32'd0);

        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 5);
            case (r)
                0, 1, 2: st = 4'h9;
                3:       st = 4'h8;
                4:       st = 4'hB;
                default: st = 4'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 4) == 4) n = 8'd200;
            else n = 8'(60 + $urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) v = 8'd0;
            else v = 8'($urandom_range(1, 127));
            ev("rand", st, n, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
